// File: rtl/shift_pkg.sv
// Shared encodings for the universal shift register: operation modes,
// burst FSM states and a helper that flags modes which move bits.
package shift_pkg;

  typedef enum logic [2:0] {
    MODE_HOLD  = 3'd0,
    MODE_SHL   = 3'd1,
    MODE_SHR   = 3'd2,
    MODE_ROL   = 3'd3,
    MODE_ROR   = 3'd4,
    MODE_LOAD  = 3'd5,
    MODE_ASR   = 3'd6,
    MODE_CLEAR = 3'd7
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // True for modes that shift or rotate, i.e. those that produce an out bit.
  function automatic logic is_shift_op(input mode_e m);
    return (m == MODE_SHL) || (m == MODE_SHR) || (m == MODE_ROL) ||
           (m == MODE_ROR) || (m == MODE_ASR);
  endfunction

endpackage

// File: rtl/shift_core.sv
// Combinational next-value logic: computes the register update and the bit
// leaving the register for a given mode.
module shift_core
  import shift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q,
  input  logic [2:0]       mode,
  input  logic             sin,
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] q_next,
  output logic             out_bit
);

  always_comb begin
    q_next  = q;
    out_bit = 1'b0;
    case (mode_e'(mode))
      MODE_HOLD:  q_next = q;
      MODE_SHL: begin
        q_next  = {q[WIDTH-2:0], sin};
        out_bit = q[WIDTH-1];
      end
      MODE_SHR: begin
        q_next  = {sin, q[WIDTH-1:1]};
        out_bit = q[0];
      end
      MODE_ROL: begin
        q_next  = {q[WIDTH-2:0], q[WIDTH-1]};
        out_bit = q[WIDTH-1];
      end
      MODE_ROR: begin
        q_next  = {q[0], q[WIDTH-1:1]};
        out_bit = q[0];
      end
      MODE_LOAD:  q_next = load_data;
      MODE_ASR: begin
        q_next  = {q[WIDTH-1], q[WIDTH-1:1]};
        out_bit = q[0];
      end
      MODE_CLEAR: q_next = '0;
      default:    q_next = q;
    endcase
  end

endmodule

// File: rtl/module_shift_univ.sv
// Universal shift register with single-step operation and counted bursts.
// state  | meaning
// IDLE   | en applies mode once per edge; start launches a burst
// SHIFT  | latched mode applied each edge, counter counts down to zero
// DONE   | one-cycle completion pulse, then back to IDLE
module module_shift_univ
  import shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] load_data,
  input  logic             sin,
  input  logic             start,
  input  logic [CNT_W-1:0] n_shift,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  mode_e            mode_lat_q, mode_lat_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] reg_q, reg_d;
  logic             sout_q, sout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [2:0]       core_mode;
  logic [WIDTH-1:0] core_q_next;
  logic             core_out;

  assign core_mode = (state_q == ST_SHIFT) ? mode_lat_q : mode;

  shift_core #(.WIDTH(WIDTH)) u_core (
    .q         (reg_q),
    .mode      (core_mode),
    .sin       (sin),
    .load_data (load_data),
    .q_next    (core_q_next),
    .out_bit   (core_out)
  );

  always_comb begin
    state_d    = state_q;
    mode_lat_d = mode_lat_q;
    cnt_d      = cnt_q;
    reg_d      = reg_q;
    sout_d     = sout_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mode_lat_d = mode_e'(mode);
          // Non-moving modes or zero length finish without touching q.
          if (!is_shift_op(mode_e'(mode)) || (n_shift == '0)) begin
            cnt_d   = '0;
            state_d = ST_DONE;
          end else begin
            cnt_d   = n_shift;
            state_d = ST_SHIFT;
          end
        end else if (en) begin
          reg_d = core_q_next;
          if (is_shift_op(mode_e'(mode))) sout_d = core_out;
        end
      end
      ST_SHIFT: begin
        reg_d  = core_q_next;
        sout_d = core_out;
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_SHIFT);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      mode_lat_q <= MODE_HOLD;
      cnt_q      <= '0;
      reg_q      <= '0;
      sout_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_lat_q <= mode_lat_d;
      cnt_q      <= cnt_d;
      reg_q      <= reg_d;
      sout_q     <= sout_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign q    = reg_q;
  assign sout = sout_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: doc/module_shift_univ.md
MODULE_SHIFT_UNIV -- requirements
Module: module_shift_univ

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the register width in bits (minimum 2).
REQ-002 The block SHALL have parameter CNT_W, default 4, giving the burst-count width in bits.
REQ-003 Port clk SHALL be an input of width 1: the single clock; all state changes on its rising edge.
REQ-004 Port rst_n SHALL be an input of width 1: reset, synchronous and active-low.
REQ-005 Port en SHALL be an input of width 1: single-step enable, used in IDLE only.
REQ-006 Port mode SHALL be an input of width 3: operation select.
REQ-007 Port load_data SHALL be an input of width WIDTH: the parallel-load value.
REQ-008 Port sin SHALL be an input of width 1: serial input bit.
REQ-009 Port start SHALL be an input of width 1: burst request.
REQ-010 Port n_shift SHALL be an input of width CNT_W: burst length.
REQ-011 Port q SHALL be an output of width WIDTH: register contents.
REQ-012 Port sout SHALL be an output of width 1: last bit shifted out, registered.
REQ-013 Port busy SHALL be an output of width 1: burst in progress.
REQ-014 Port done SHALL be an output of width 1: one-cycle burst-complete pulse.

Function
REQ-015 The mode encodings SHALL be: 0 HOLD, 1 SHL (sin enters bit0), 2 SHR (sin enters MSB), 3 ROL, 4 ROR, 5 LOAD (q<=load_data), 6 ASR (MSB replicated), 7 CLEAR (q<=0).
REQ-016 The FSM SHALL have exactly three states, IDLE, SHIFT and DONE; busy=1 only in SHIFT and done=1 only in DONE.
REQ-017 In IDLE with start=0 and en=1, the block SHALL apply mode once at that edge; with en=0, q SHALL hold.
REQ-018 In IDLE, start=1 SHALL take priority over en: the block latches mode and n_shift, performs no q update at that edge, and goes to SHIFT (n_shift>0) or DONE (n_shift=0).
REQ-019 In SHIFT, each edge SHALL apply the latched mode once and decrement the counter; the edge at which the counter reaches 0 SHALL move the FSM to DONE, so busy stays high for exactly n_shift cycles.
REQ-020 A burst with latched mode HOLD, LOAD or CLEAR SHALL go straight from start to DONE without changing q.
REQ-021 DONE SHALL last exactly one cycle, then return to IDLE; start and en SHALL be ignored in SHIFT and DONE.
REQ-022 sout SHALL update only on edges where a shift or rotate occurs: old q[WIDTH-1] for SHL/ROL, old q[0] for SHR/ROR/ASR; otherwise sout holds.
REQ-023 New values of mode, sin or load_data during SHIFT SHALL NOT change the latched mode; sin SHALL still be sampled on every shift edge.

Reset
REQ-024 When rst_n=0 at a rising edge, the block SHALL set q=0, sout=0, busy=0, done=0, the counter to 0 and the FSM to IDLE, overriding all other inputs.
REQ-025 A reset during SHIFT or DONE SHALL abort the burst and SHALL NOT produce a done pulse.

Structure
REQ-026 Package shift_pkg SHALL hold the mode encodings and the FSM state encoding as named constants.
REQ-027 The combinational next-value logic SHALL be one sub-module, shift_core (inputs q, mode, sin, load_data; outputs q_next, out_bit); the top level SHALL hold the FSM, counter and registers.

Verification (WIDTH=8, CNT_W=4)
REQ-028 Reset test: with q=0xFF, hold rst_n=0 for one edge -> q=0x00, sout=0, busy=0, done=0.
REQ-029 Single-step test: LOAD 0xA5 with en=1, then SHL with sin=1 -> q=0x4B, sout=1.
REQ-030 Burst ROR test: from q=0x81, start with n_shift=3 -> q steps 0xC0, 0x60, 0x30; busy high 3 cycles; then done high 1 cycle; sout=0.
REQ-031 Burst ASR test: from q=0x90, n_shift=2 -> q=0xC8, then 0xE4; then done pulse.
REQ-032 Zero-length test: start with n_shift=0 -> done on the next cycle, busy never high, q unchanged.
REQ-033 Busy-ignore and abort test: pulse en and start during SHIFT -> no effect; assert rst_n=0 mid-burst -> q=0, FSM in IDLE, no done pulse.
